// File: rtl/fp_add_seq_ctrl.sv
// Sequencing controller for the iterative 32-bit floating-point adder.
// It walks the datapath through load, align, add, normalize, round and output, one strobe per cycle.
module fp_add_seq_ctrl #(
  parameter int MAX_ALIGN = 27,
  parameter int MAX_NORM  = 24,
  parameter int CNT_W     = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] exp_diff,
  input  logic       special,
  input  logic       sum_ovf,
  input  logic       sum_zero,
  input  logic       norm_msb,
  input  logic       round_carry,
  output logic       busy,
  output logic       ld_en,
  output logic       align_shr,
  output logic       add_en,
  output logic       shl1,
  output logic       shr1,
  output logic       rnd_en,
  output logic       out_en,
  output logic       done,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ALIGN = 3'd2,
    ADD   = 3'd3,
    NORM  = 3'd4,
    ROUND = 3'd5,
    RCHK  = 3'd6,
    DONE  = 3'd7
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  align_cnt_q, align_cnt_d;
  logic [CNT_W-1:0]  norm_cnt_q, norm_cnt_d;
  logic              special_q, special_d;
  logic [CNT_W-1:0]  align_init;

  // Differences beyond MAX_ALIGN flush the mantissa into sticky anyway, so clamp the shift count.
  assign align_init = (exp_diff > 8'(MAX_ALIGN)) ? CNT_W'(MAX_ALIGN) : exp_diff[CNT_W-1:0];
  assign state_o    = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      align_cnt_q <= '0;
      norm_cnt_q  <= '0;
      special_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      align_cnt_q <= align_cnt_d;
      norm_cnt_q  <= norm_cnt_d;
      special_q   <= special_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    align_cnt_d = align_cnt_q;
    norm_cnt_d  = norm_cnt_q;
    special_d   = special_q;
    busy        = 1'b0;
    ld_en       = 1'b0;
    align_shr   = 1'b0;
    add_en      = 1'b0;
    shl1        = 1'b0;
    shr1        = 1'b0;
    rnd_en      = 1'b0;
    out_en      = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          align_cnt_d = align_init;
          special_d   = special;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        busy       = 1'b1;
        ld_en      = 1'b1;
        norm_cnt_d = '0;
        if (special_q)                state_d = DONE;
        else if (align_cnt_q != '0)   state_d = ALIGN;
        else                          state_d = ADD;
      end
      ALIGN: begin
        busy        = 1'b1;
        align_shr   = 1'b1;
        align_cnt_d = align_cnt_q - CNT_W'(1);
        if (align_cnt_q == CNT_W'(1)) state_d = ADD;
      end
      ADD: begin
        busy    = 1'b1;
        add_en  = 1'b1;
        state_d = NORM;
      end
      // Carry-out wins over the other flags; a zero sum needs no shifting at all.
      NORM: begin
        busy = 1'b1;
        if (sum_ovf) begin
          shr1    = 1'b1;
          state_d = ROUND;
        end else if (sum_zero) begin
          state_d = ROUND;
        end else if (!norm_msb && (norm_cnt_q < CNT_W'(MAX_NORM))) begin
          shl1       = 1'b1;
          norm_cnt_d = norm_cnt_q + CNT_W'(1);
        end else begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        busy    = 1'b1;
        rnd_en  = 1'b1;
        state_d = RCHK;
      end
      RCHK: begin
        busy    = 1'b1;
        shr1    = round_carry;
        state_d = DONE;
      end
      DONE: begin
        busy   = 1'b1;
        out_en = 1'b1;
        done   = 1'b1;
        if (start) begin
          align_cnt_d = align_init;
          special_d   = special;
          state_d     = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
